// File: rtl/seg7_decoder_pkg.sv
// Shared definitions for the 7-segment decoder and encoder: filter FSM states,
// the segment pattern of each digit ({A,B,C,D,E,F,G}) and the special codes.
package seg7_decoder_pkg;

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_LOCKED = 2'd2
  } filt_state_t;

  localparam logic [3:0] CODE_INVALID = 4'hE;
  localparam logic [3:0] CODE_BLANK   = 4'hF;

  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  // Pattern the encoder shows for anything that is not a digit or blank (G only).
  localparam logic [6:0] SEG_DASH  = 7'b0000001;

  localparam int unsigned CNT_W = 24;

  function automatic logic [3:0] seg7_decode(input logic [6:0] segs);
    case (segs)
      SEG_0:     return 4'd0;
      SEG_1:     return 4'd1;
      SEG_2:     return 4'd2;
      SEG_3:     return 4'd3;
      SEG_4:     return 4'd4;
      SEG_5:     return 4'd5;
      SEG_6:     return 4'd6;
      SEG_7:     return 4'd7;
      SEG_8:     return 4'd8;
      SEG_9:     return 4'd9;
      SEG_BLANK: return CODE_BLANK;
      default:   return CODE_INVALID;
    endcase
  endfunction

  function automatic logic [6:0] seg7_encode(input logic [3:0] code);
    case (code)
      4'd0:       return SEG_0;
      4'd1:       return SEG_1;
      4'd2:       return SEG_2;
      4'd3:       return SEG_3;
      4'd4:       return SEG_4;
      4'd5:       return SEG_5;
      4'd6:       return SEG_6;
      4'd7:       return SEG_7;
      4'd8:       return SEG_8;
      4'd9:       return SEG_9;
      CODE_BLANK: return SEG_BLANK;
      default:    return SEG_DASH;
    endcase
  endfunction

endpackage

// File: rtl/seg7_stable_filter.sv
// Two-flop synchronizer plus stability filter: a pattern is accepted after
// STABLE_CYCLES consecutive identical samples; accept is a one-cycle pulse.
module seg7_stable_filter
  import seg7_decoder_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 133000,
  parameter bit          ACTIVE_LOW    = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] seg,
  output logic [7:0] held,
  output logic       accept
);

  localparam logic [CNT_W-1:0] TARGET = CNT_W'(STABLE_CYCLES);

  if (STABLE_CYCLES < 2 || STABLE_CYCLES > 32'h00FF_FFFF) begin : g_range_check
    $error("seg7_stable_filter: STABLE_CYCLES out of range 2..2^24-1");
  end

  logic [7:0]       sync1;
  logic [7:0]       sync2;
  logic [7:0]       sample;
  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] count_inc;
  filt_state_t      state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= seg;
      sync2 <= sync1;
    end
  end

  assign sample    = ACTIVE_LOW ? ~sync2 : sync2;
  // Saturating increment keeps the count pinned once it reaches all-ones.
  assign count_inc = (&counter) ? counter : counter + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_WAIT;
      counter <= '0;
      held    <= '0;
      accept  <= 1'b0;
    end else begin
      accept <= 1'b0;
      case (state)
        ST_WAIT: begin
          state   <= ST_SETTLE;
          counter <= CNT_W'(1);
          held    <= sample;
        end
        ST_SETTLE: begin
          if (sample != held) begin
            held    <= sample;
            counter <= CNT_W'(1);
          end else begin
            counter <= count_inc;
            if (count_inc >= TARGET) begin
              state  <= ST_LOCKED;
              accept <= 1'b1;
            end
          end
        end
        ST_LOCKED: begin
          if (sample != held) begin
            held    <= sample;
            counter <= CNT_W'(1);
            state   <= ST_SETTLE;
          end else begin
            counter <= count_inc;
          end
        end
        default: begin
          state   <= ST_WAIT;
          counter <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/seg7_decoder.sv
// Decodes a filtered 7-segment pattern into a digit code and presents each new
// pattern as a valid/ready event; events arriving while one is stalled are dropped.
module seg7_decoder
  import seg7_decoder_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 133000,
  parameter bit          ACTIVE_LOW    = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] seg,
  output logic [3:0] digit,
  output logic       dp,
  output logic       blank,
  output logic       invalid,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       overrun
);

  logic [7:0] held;
  logic       accept;
  logic [3:0] code;
  logic       have_last;
  logic [7:0] last_pattern;
  logic       new_event;

  seg7_stable_filter #(
    .STABLE_CYCLES(STABLE_CYCLES),
    .ACTIVE_LOW   (ACTIVE_LOW)
  ) u_filter (
    .clk   (clk),
    .rst   (rst),
    .seg   (seg),
    .held  (held),
    .accept(accept)
  );

  assign code      = seg7_decode(held[7:1]);
  // Re-accepting the same pattern (e.g. after a short glitch) is not a new event.
  assign new_event = accept && (!have_last || (held != last_pattern));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      have_last    <= 1'b0;
      last_pattern <= '0;
      digit        <= 4'h0;
      dp           <= 1'b0;
      blank        <= 1'b0;
      invalid      <= 1'b0;
      out_valid    <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (accept) begin
        have_last    <= 1'b1;
        last_pattern <= held;
      end
      if (new_event && out_valid && !out_ready) begin
        overrun <= 1'b1;
      end else if (new_event) begin
        digit     <= code;
        dp        <= held[0];
        blank     <= (code == CODE_BLANK);
        invalid   <= (code == CODE_INVALID);
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
